// File: rtl/digit_bitmap_reader_if.sv
// Pixel-side bundle between a multi-digit HUD object and its bitmap reader.
// The HUD (master) drives offsets, strobes and digit configuration; the reader (slave) returns colour.
interface digit_bitmap_reader_if;
  logic        startOfFrame;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic [5:0]  drawingRequest;
  logic [23:0] digits;
  logic [2:0]  numDigits;
  logic        leadingZeroBlank;
  logic [7:0]  RGBout;
  logic        drawingRequestOut;

  modport master (
    output startOfFrame, offsetX, offsetY, drawingRequest, digits, numDigits, leadingZeroBlank,
    input  RGBout, drawingRequestOut
  );
  modport slave (
    input  startOfFrame, offsetX, offsetY, drawingRequest, digits, numDigits, leadingZeroBlank,
    output RGBout, drawingRequestOut
  );
endinterface

// File: rtl/digit_bitmap_reader.sv
// Six-digit HUD renderer: frame-latched digit shadow, digit select / blanking stage,
// then a 1-bpp 16x16 font lookup stage. Two-cycle latency, one pixel per clock.
module digit_bitmap_reader #(
  parameter int          OBJECT_WIDTH_X    = 16,
  parameter int          OBJECT_HEIGHT_Y   = 16,
  parameter logic [7:0]  FG_COLOR          = 8'h1F,
  parameter logic [7:0]  TRANSPARENT_COLOR = 8'hFF
) (
  input  logic                 clk,
  input  logic                 resetN,
  digit_bitmap_reader_if.slave bus
);

  // Seven-segment style glyphs on a native 16x16 grid; leftmost hex digit is column 0.
  // Code 10 is the dash: only the two centre rows lit, full width.
  localparam logic [0:15] FONT [0:10][0:15] = '{
    '{16'h0000, 16'h1FF8, 16'h1FF8, 16'h1818, 16'h1818, 16'h1818, 16'h1818, 16'h1818,
      16'h1818, 16'h1818, 16'h1818, 16'h1818, 16'h1818, 16'h1FF8, 16'h1FF8, 16'h0000},
    '{16'h0000, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018,
      16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0000},
    '{16'h0000, 16'h1FF8, 16'h1FF8, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h1FF8,
      16'h1FF8, 16'h1800, 16'h1800, 16'h1800, 16'h1800, 16'h1FF8, 16'h1FF8, 16'h0000},
    '{16'h0000, 16'h1FF8, 16'h1FF8, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h1FF8,
      16'h1FF8, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h1FF8, 16'h1FF8, 16'h0000},
    '{16'h0000, 16'h1818, 16'h1818, 16'h1818, 16'h1818, 16'h1818, 16'h1818, 16'h1FF8,
      16'h1FF8, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0000},
    '{16'h0000, 16'h1FF8, 16'h1FF8, 16'h1800, 16'h1800, 16'h1800, 16'h1800, 16'h1FF8,
      16'h1FF8, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h1FF8, 16'h1FF8, 16'h0000},
    '{16'h0000, 16'h1FF8, 16'h1FF8, 16'h1800, 16'h1800, 16'h1800, 16'h1800, 16'h1FF8,
      16'h1FF8, 16'h1818, 16'h1818, 16'h1818, 16'h1818, 16'h1FF8, 16'h1FF8, 16'h0000},
    '{16'h0000, 16'h1FF8, 16'h1FF8, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018,
      16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0000},
    '{16'h0000, 16'h1FF8, 16'h1FF8, 16'h1818, 16'h1818, 16'h1818, 16'h1818, 16'h1FF8,
      16'h1FF8, 16'h1818, 16'h1818, 16'h1818, 16'h1818, 16'h1FF8, 16'h1FF8, 16'h0000},
    '{16'h0000, 16'h1FF8, 16'h1FF8, 16'h1818, 16'h1818, 16'h1818, 16'h1818, 16'h1FF8,
      16'h1FF8, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h1FF8, 16'h1FF8, 16'h0000},
    '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF,
      16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}
  };

  // Frame shadow
  logic [23:0] dig_q;
  logic [2:0]  num_q;
  logic        lzb_q;
  logic [2:0]  num_clamp;

  // Stage 1 / stage 2 registers
  logic        v1_q, blank_q;
  logic [3:0]  code_q, fx_q, fy_q;
  logic        dro_q;
  logic [7:0]  rgb_q;

  // Stage 1 combinational
  logic [2:0]  sel;
  logic        hit, allz, inrng, blank_d, pix, dro_d;
  logic [10:0] xbase, col;
  logic [3:0]  nib, code_d, fx_d, fy_d;

  always_comb begin
    num_clamp = bus.numDigits;
    if (bus.numDigits == 3'd0)     num_clamp = 3'd1;
    else if (bus.numDigits > 3'd6) num_clamp = 3'd6;
  end

  always_comb begin
    sel  = '0;
    hit  = 1'b0;
    nib  = '0;
    allz = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      if (bus.drawingRequest[i] && (3'(i) < num_q)) begin
        sel = 3'(i);
        hit = 1'b1;
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (3'(i) == sel) nib = dig_q[(5-i)*4 +: 4];
      if ((3'(i) <= sel) && (dig_q[(5-i)*4 +: 4] != 4'd0)) allz = 1'b0;
    end
    // Unsigned compare catches a left-of-bracket offset before the subtraction wraps.
    xbase   = 11'(sel) * 11'(OBJECT_WIDTH_X);
    col     = bus.offsetX - xbase;
    inrng   = hit && (bus.offsetX >= xbase) && (col < 11'(OBJECT_WIDTH_X))
              && (bus.offsetY < 11'(OBJECT_HEIGHT_Y));
    code_d  = (nib > 4'd9) ? 4'd10 : nib;
    blank_d = lzb_q && allz && (sel != (num_q - 3'd1));
    fx_d    = 4'((int'(col) * 16) / OBJECT_WIDTH_X);
    fy_d    = 4'((int'(bus.offsetY) * 16) / OBJECT_HEIGHT_Y);
  end

  always_comb begin
    pix   = FONT[code_q][fy_q][fx_q];
    dro_d = v1_q & pix & ~blank_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dig_q   <= '0;
      num_q   <= 3'd1;
      lzb_q   <= 1'b0;
      v1_q    <= 1'b0;
      blank_q <= 1'b0;
      code_q  <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      dro_q   <= 1'b0;
      rgb_q   <= TRANSPARENT_COLOR;
    end else begin
      if (bus.startOfFrame) begin
        dig_q <= bus.digits;
        num_q <= num_clamp;
        lzb_q <= bus.leadingZeroBlank;
      end
      v1_q    <= inrng;
      blank_q <= blank_d;
      code_q  <= code_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      dro_q   <= dro_d;
      rgb_q   <= dro_d ? FG_COLOR : TRANSPARENT_COLOR;
    end
  end

  assign bus.drawingRequestOut = dro_q;
  assign bus.RGBout            = rgb_q;

endmodule

// File: tb/tb_digit_bitmap_reader.sv
// Directed bench: each driven pixel pushes its expected result; a negedge monitor
// pops it two cycles later and compares both outputs.
module tb_digit_bitmap_reader;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  digit_bitmap_reader_if bus();

  digit_bitmap_reader dut (.clk(clk), .resetN(resetN), .bus(bus));

  typedef struct {
    int    due;
    logic  exp;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      logic [7:0] exp_rgb;
      e = q.pop_front();
      exp_rgb = e.exp ? 8'h1F : 8'hFF;
      vecs++;
      if (e.due != cyc || bus.drawingRequestOut !== e.exp || bus.RGBout !== exp_rgb) begin
        errs++;
        $display("FAIL %s: got dro=%b rgb=%h, want dro=%b rgb=%h (due %0d, cyc %0d)",
                 e.name, bus.drawingRequestOut, bus.RGBout, e.exp, exp_rgb, e.due, cyc);
      end
    end
  end

  task automatic px(input logic [5:0] dr, input int x, input int y, input logic e,
                    input string nm, input logic sof = 1'b0);
    exp_t t;
    @(negedge clk);
    bus.drawingRequest = dr;
    bus.offsetX        = 11'(x);
    bus.offsetY        = 11'(y);
    bus.startOfFrame   = sof;
    t.due = cyc + 2; t.exp = e; t.name = nm;
    q.push_back(t);
  endtask

  task automatic frame(input logic [23:0] d, input logic [2:0] n, input logic lzb);
    @(negedge clk);
    bus.digits           = d;
    bus.numDigits        = n;
    bus.leadingZeroBlank = lzb;
    bus.drawingRequest   = '0;
    bus.startOfFrame     = 1'b1;
    @(negedge clk);
    bus.startOfFrame     = 1'b0;
  endtask

  initial begin
    int budget;
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.offsetX = '0; bus.offsetY = '0;
    bus.drawingRequest = '0;
    bus.digits = 24'h888888; bus.numDigits = 3'd6; bus.leadingZeroBlank = 1'b0;

    // Reset held with requests active: transparent throughout
    for (int i = 0; i < 4; i++) px(6'b000001, 5, 1, 1'b0, "rst_hold");
    @(negedge clk);
    resetN = 1'b1;
    px(6'b000001, 5, 1, 1'b1, "rst_d1_zero");
    px(6'b000010, 21, 1, 1'b0, "rst_d2_inactive");

    // Digit 6 = 7, no blanking
    frame(24'h000007, 3'd6, 1'b0);
    px(6'b100000, 87, 8, 1'b0, "t2_font7_r8c7");
    px(6'b100000, 91, 8, 1'b1, "t2_font7_r8c11");
    px(6'b100000, 96, 1, 1'b0, "t2_col_eq_w");
    px(6'b100000, 91, 16, 1'b0, "t2_row_eq_h");
    px(6'b000001, 5, 1, 1'b1, "t2_d1_zero_shown");

    // Leading-zero blanking
    frame(24'h000007, 3'd6, 1'b1);
    px(6'b000001, 5, 1, 1'b0, "t3_d1_blank");
    px(6'b010000, 69, 1, 1'b0, "t3_d5_blank");
    px(6'b100000, 85, 1, 1'b1, "t3_d6_seven");
    frame(24'h000000, 3'd6, 1'b1);
    px(6'b010000, 69, 1, 1'b0, "t3_zero_d5_blank");
    px(6'b100000, 85, 1, 1'b1, "t3_zero_d6_last");

    // Nibble C renders as dash at digit 2
    frame(24'h0C0000, 3'd6, 1'b0);
    for (int x = 16; x < 32; x++) px(6'b000010, x, 7, 1'b1, "t4_dash_row7");
    for (int x = 16; x < 32; x += 5) px(6'b000010, x, 6, 1'b0, "t4_dash_row6");

    // Frame-latched shadow, SOF coincident with a pixel
    frame(24'h100000, 3'd6, 1'b0);
    px(6'b000001, 5, 1, 1'b0, "t5_old_one");
    bus.digits = 24'h800000;
    px(6'b000001, 5, 1, 1'b0, "t5_midframe_hold");
    px(6'b000001, 5, 1, 1'b0, "t5_sof_same_px", 1'b1);
    px(6'b000001, 5, 1, 1'b1, "t5_after_sof");

    // Active-digit limit, select priority, negative column, clamping
    frame(24'h888888, 3'd3, 1'b0);
    px(6'b001000, 53, 1, 1'b0, "t6_d4_inactive");
    px(6'b000100, 37, 1, 1'b1, "t6_d3_active");
    px(6'b000010, 5, 1, 1'b0, "t6_neg_col");
    px(6'b000110, 21, 1, 1'b1, "t6_lowest_sel");
    frame(24'h888888, 3'd7, 1'b0);
    px(6'b100000, 85, 1, 1'b1, "t6_num7_as6");
    frame(24'h888888, 3'd0, 1'b0);
    px(6'b000010, 21, 1, 1'b0, "t6_num0_d2");
    px(6'b000001, 5, 1, 1'b1, "t6_num0_d1");

    // Reset mid-frame kills the in-flight pixel and restores the 1-digit zero shadow
    px(6'b000001, 5, 1, 1'b0, "rst_inflight");
    @(negedge clk);
    resetN = 1'b0;
    bus.drawingRequest = '0;
    @(negedge clk);
    resetN = 1'b1;
    px(6'b000010, 21, 1, 1'b0, "rst2_d2_inactive");
    px(6'b000001, 5, 1, 1'b1, "rst2_d1_zero");

    @(negedge clk);
    bus.drawingRequest = '0;
    budget = 0;
    while (q.size() > 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      errs++;
      $display("FAIL drain: %0d expected results never compared, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
